// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
// Holds the controller's operation codes, the FSM state type and the shift-op classifier.
package alu_pkg;

    localparam int ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_t;

    function automatic logic is_shift(input logic [ALU_CTRL_W-1:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shifter_iter.sv
// Iterative shifter: moves one bit position per clock until the count is exhausted.
// done flags the last step; dout is the value after that step.
module alu_shifter_iter
    import alu_pkg::*;
#(
    parameter  int XLEN    = 32,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               start,
    input  alu_ctrl_t          shift_op,
    input  logic [XLEN-1:0]    din,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               done,
    output logic [XLEN-1:0]    dout
);

    logic [XLEN-1:0]    work;
    logic [XLEN-1:0]    work_sh;
    logic [SHAMT_W-1:0] cnt;
    logic               dir_right;
    logic               arith;

    // SRA feeds the sign bit back in; SRL and SLL feed zeros.
    always_comb begin
        if (dir_right) begin
            work_sh = {arith & work[XLEN-1], work[XLEN-1:1]};
        end else begin
            work_sh = {work[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            work      <= '0;
            cnt       <= '0;
            dir_right <= 1'b0;
            arith     <= 1'b0;
        end else if (start) begin
            work      <= din;
            cnt       <= shamt;
            dir_right <= (shift_op != ALU_SLL);
            arith     <= (shift_op == ALU_SRA);
        end else if (cnt != '0) begin
            work <= work_sh;
            cnt  <= cnt - 1'b1;
        end
    end

    assign done = (cnt == SHAMT_W'(1));
    assign dout = work_sh;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides and a single-entry result register.
// Logic/arith ops complete in one cycle; shifts by a non-zero amount go through the iterative shifter.
//
//   state    | meaning
//   ST_IDLE  | ready for an op whenever the result register is free or retiring
//   ST_SHIFT | iterative shift in progress, input side stalled
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter  int XLEN    = 32,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_CTRL_W-1:0] alu_ctrl,
    input  logic [XLEN-1:0]       op_a,
    input  logic [XLEN-1:0]       op_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       result,
    output logic                  zero,
    output logic                  illegal
);

    alu_state_t         state;
    alu_state_t         state_nxt;
    alu_ctrl_t          ctrl;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;
    logic               long_shift;
    logic               sh_start;
    logic               sh_done;
    logic [XLEN-1:0]    sh_res;
    logic [XLEN-1:0]    quick_res;
    logic               quick_ill;
    logic               ov_nxt;
    logic [XLEN-1:0]    res_nxt;
    logic               zero_nxt;
    logic               ill_nxt;

    assign ctrl       = alu_ctrl_t'(alu_ctrl);
    assign shamt      = op_b[SHAMT_W-1:0];
    assign in_ready   = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign long_shift = is_shift(alu_ctrl) && (shamt != '0);
    assign sh_start   = accept && long_shift && !flush;

    // Single-cycle datapath; a zero-amount shift is just a pass-through of op_a.
    always_comb begin
        quick_res = '0;
        quick_ill = 1'b0;
        case (ctrl)
            ALU_AND:  quick_res = op_a & op_b;
            ALU_OR:   quick_res = op_a | op_b;
            ALU_ADD:  quick_res = op_a + op_b;
            ALU_SUB:  quick_res = op_a - op_b;
            ALU_XOR:  quick_res = op_a ^ op_b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  quick_res = op_a;
            ALU_SLT:  quick_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: quick_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            default:  quick_ill = 1'b1;
        endcase
    end

    alu_shifter_iter #(
        .XLEN (XLEN)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .start    (sh_start),
        .shift_op (ctrl),
        .din      (op_a),
        .shamt    (shamt),
        .done     (sh_done),
        .dout     (sh_res)
    );

    always_comb begin
        state_nxt = state;
        ov_nxt    = out_valid && !out_ready;
        res_nxt   = result;
        zero_nxt  = zero;
        ill_nxt   = illegal;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (long_shift) begin
                        state_nxt = ST_SHIFT;
                    end else begin
                        ov_nxt   = 1'b1;
                        res_nxt  = quick_res;
                        zero_nxt = (quick_res == '0);
                        ill_nxt  = quick_ill;
                    end
                end
            end
            ST_SHIFT: begin
                if (sh_done) begin
                    state_nxt = ST_IDLE;
                    ov_nxt    = 1'b1;
                    res_nxt   = sh_res;
                    zero_nxt  = (sh_res == '0);
                    ill_nxt   = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Flush discards anything pending but leaves the last result value in place.
        if (flush) begin
            state_nxt = ST_IDLE;
            ov_nxt    = 1'b0;
            res_nxt   = result;
            zero_nxt  = zero;
            ill_nxt   = illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= ov_nxt;
            result    <= res_nxt;
            zero      <= zero_nxt;
            illegal   <= ill_nxt;
        end
    end

endmodule
